// File: rtl/adc_sample_seq_if.sv
// Sequencer-side bundle: run control, ADC start/eoc, capture strobe, sample valid/ready, error status.
interface adc_sample_seq_if #(
  parameter int PER_W = 16
);
  logic             ctrl_en;
  logic [PER_W-1:0] period;
  logic             adc_start;
  logic             adc_eoc;
  logic             adc2tmu_en;
  logic             sample_valid;
  logic             sample_ready;
  logic [7:0]       overrun_cnt;
  logic             timeout_err;
  logic             err_clr;

  modport master (
    input  ctrl_en, period, adc_eoc, sample_ready, err_clr,
    output adc_start, adc2tmu_en, sample_valid, overrun_cnt, timeout_err
  );

  modport slave (
    output ctrl_en, period, adc_eoc, sample_ready, err_clr,
    input  adc_start, adc2tmu_en, sample_valid, overrun_cnt, timeout_err
  );
endinterface

// File: rtl/adc_sample_seq.sv
// ADC sequencer: tick->adc_start 1 cycle, eoc->sample_valid 3 cycles; valid holds until ready, ticks meanwhile count as overruns.
// Conversion timeout (sticky timeout_err, back to WAIT) is built only when ADC_SEQ_TIMEOUT_EN is defined.
module adc_sample_seq #(
  parameter int PER_W   = 16,
  parameter int TMO_CYC = 256
) (
  input  logic             clk,
  input  logic             rstn,
  adc_sample_seq_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_START, S_CONV, S_CAP1, S_CAP2, S_VALID
  } state_t;

  state_t           state_q, state_d;
  logic [PER_W-1:0] pcnt_q, pcnt_d;
  logic [PER_W-1:0] per_eff, per_last;
  logic             tick, tmo_hit;
  logic             adc_start_q, adc2tmu_en_q, sample_valid_q;
  logic [7:0]       overrun_q, overrun_d;

  // A period shrunk below the running count wraps on the next compare.
  assign per_eff  = (bus.period < PER_W'(8)) ? PER_W'(8) : bus.period;
  assign per_last = per_eff - PER_W'(1);
  assign tick     = bus.ctrl_en && (pcnt_q >= per_last);

  always_comb begin
    pcnt_d = pcnt_q + PER_W'(1);
    if (!bus.ctrl_en || tick) pcnt_d = '0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.ctrl_en) state_d = S_WAIT;
      S_WAIT:  if (tick) state_d = S_START;
      S_START: state_d = S_CONV;
      S_CONV: begin
        if (bus.adc_eoc)  state_d = S_CAP1;
        else if (tmo_hit) state_d = S_WAIT;
      end
      S_CAP1:  state_d = S_CAP2;
      S_CAP2:  state_d = S_VALID;
      S_VALID: if (bus.sample_ready) state_d = S_WAIT;
      default: state_d = S_IDLE;
    endcase
    if (!bus.ctrl_en) state_d = S_IDLE;
  end

  always_comb begin
    overrun_d = overrun_q;
    if (bus.err_clr)
      overrun_d = '0;
    else if (tick && (state_q != S_WAIT) && (overrun_q != 8'hFF))
      overrun_d = overrun_q + 8'd1;
  end

  // Strobes are decoded from the next state so they are registered yet aligned with it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= S_IDLE;
      pcnt_q         <= '0;
      adc_start_q    <= 1'b0;
      adc2tmu_en_q   <= 1'b0;
      sample_valid_q <= 1'b0;
      overrun_q      <= '0;
    end else begin
      state_q        <= state_d;
      pcnt_q         <= pcnt_d;
      adc_start_q    <= (state_d == S_START);
      adc2tmu_en_q   <= (state_d == S_CAP1) || (state_d == S_CAP2);
      sample_valid_q <= (state_d == S_VALID);
      overrun_q      <= overrun_d;
    end
  end

  assign bus.adc_start    = adc_start_q;
  assign bus.adc2tmu_en   = adc2tmu_en_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.overrun_cnt  = overrun_q;

`ifdef ADC_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             timeout_err_q, timeout_err_d;

  // Fires on the last allowed CONV cycle; tmo_q is 0 on the first CONV cycle.
  assign tmo_hit = (state_q == S_CONV) && !bus.adc_eoc && (tmo_q == TMO_W'(TMO_CYC - 1));

  always_comb begin
    tmo_d = '0;
    if ((state_q == S_CONV) && (state_d == S_CONV)) tmo_d = tmo_q + TMO_W'(1);
    timeout_err_d = timeout_err_q;
    if (bus.err_clr)  timeout_err_d = 1'b0;
    else if (tmo_hit) timeout_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmo_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      tmo_q         <= tmo_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.timeout_err = timeout_err_q;
`else
  assign tmo_hit = 1'b0;
  // Constant 0; the term keeps TMO_CYC referenced in the untimed build.
  assign bus.timeout_err = 1'b0 && (TMO_CYC > 0);
`endif

endmodule

// File: doc/adc_sample_seq.md
# adc_sample_seq

Sequencer for the ADC front end of the PID accelerator. It issues periodic conversion requests to the ADC, waits for end-of-conversion, and drives `adc2tmu_en` for exactly two cycles so the two-stage ADC capture register chain moves a fresh sample to its output. It then presents a valid/ready sample strobe to the PID core. It also counts dropped sample ticks (overruns) and, optionally, flags conversion timeouts.

## Interface
Parameters:
- `PER_W`, 16: width of the sample-period register.
- `TMO_CYC`, 256: conversion timeout in clk cycles (used only with the timeout feature).

Ports:
- `clk`  in  1: single system clock; all logic rising-edge.
- `rstn`  in  1: reset, asynchronous, active-low.
- `ctrl_en`  in  1: run enable; low = sequencer idle, period counter cleared.
- `period`  in  PER_W: sample period in clk cycles; values < 8 are treated as 8.
- `adc_start`  out  1: one-cycle conversion-start pulse to the ADC.
- `adc_eoc`  in  1: end-of-conversion; level sampled, first high cycle in CONV is the event.
- `adc2tmu_en`  out  1: capture enable for the two-stage ADC register chain.
- `sample_valid`  out  1: new sample present at capture-chain output.
- `sample_ready`  in  1: PID core accepts the sample.
- `overrun_cnt`  out  8: saturating count of dropped ticks.
- `timeout_err`  out  1: sticky conversion-timeout flag.
- `err_clr`  in  1: clears `overrun_cnt` and `timeout_err`.

## Operation
- Period counter `pcnt`: 0 while `ctrl_en`=0; else counts 0..P-1 and wraps, with P = max(`period`, 8). A `tick` occurs on the cycle `pcnt`==P-1. `period` is sampled every cycle; a change takes effect at the next compare.
- FSM states: IDLE, WAIT, START, CONV, CAP1, CAP2, VALID.
  - IDLE -> WAIT when `ctrl_en`=1.
  - WAIT -> START on `tick`.
  - START: `adc_start`=1 for this single cycle -> CONV.
  - CONV -> CAP1 on `adc_eoc`=1.
  - CAP1, CAP2: `adc2tmu_en`=1 in each -> VALID.
  - VALID: `sample_valid`=1 until `sample_ready`=1 is sampled, then -> WAIT.
- Overrun: a `tick` in any state other than WAIT is dropped. `overrun_cnt` increments and saturates at 255.
- `ctrl_en`=0 in any state -> IDLE at the next edge. All strobes deassert and an in-flight conversion is abandoned. A later `adc_eoc` is ignored outside CONV.
- `err_clr` has priority over a same-cycle increment or timeout set: the result is 0.
- All outputs are registered. Reset values: `adc_start`=0, `adc2tmu_en`=0, `sample_valid`=0, `overrun_cnt`=0, `timeout_err`=0, FSM=IDLE, `pcnt`=0.

## Timing
- `tick` at edge N: `adc_start` high in cycle N+1, FSM in CONV from N+2.
- `adc_eoc` sampled high at edge M: `adc2tmu_en` high in cycles M+1 and M+2. `sample_valid` high from M+3.
- `sample_ready` sampled high at edge R: `sample_valid` low from R+1. `sample_ready` high on the first VALID cycle gives a 1-cycle valid.
- Minimum tick-to-valid latency is 4 cycles (eoc already high when CONV is entered). Back-to-back operation without overrun requires P >= conversion time + 5.

## Configuration
- `ADC_SEQ_TIMEOUT_EN` defined:
  - A CONV-state cycle counter runs.
  - If `adc_eoc` has not arrived after `TMO_CYC` cycles in CONV, `timeout_err` sets (sticky) and the FSM returns to WAIT with no capture and no `sample_valid`.
- Not defined: CONV waits indefinitely, `timeout_err` is tied 0, and no timeout counter is built.

## Test plan
- Reset: hold `rstn`=0 mid-CONV, then release. All outputs must be 0, FSM in IDLE, `overrun_cnt`=0.
- Nominal: `period`=20, `ctrl_en`=1, eoc 6 cycles after `adc_start`, ready tied 1.
  - Required: `adc_start` every 20 cycles, `adc2tmu_en` exactly 2 cycles per sample, `sample_valid` 1 cycle, `overrun_cnt`=0.
- Clamp and overrun: `period`=3 (effective 8), eoc 10 cycles after start.
  - Required: ticks every 8 cycles; `overrun_cnt` increments per dropped tick and saturates at 255 after a long run.
- Backpressure: `sample_ready` held low 30 cycles with `period`=20.
  - Required: `sample_valid` held steady, 1 overrun counted, no `adc_start` until ready is accepted.
- Abort: drop `ctrl_en` during CAP1.
  - Required: `adc2tmu_en` low next cycle, no `sample_valid`, late eoc ignored, restart gives first tick 8+ cycles after re-enable.
- Timeout (macro on, `TMO_CYC`=256): never assert eoc.
  - Required: `timeout_err`=1 after 256 CONV cycles, FSM back in WAIT, `err_clr` clears it.
  - Macro off: FSM stays in CONV and `timeout_err`=0.
